// File: rtl/regfile_dump_reader.sv
// Walks a register-file index range through two combinational read ports and streams (index, value)
// pairs over a valid/ready handshake. Define REGFILE_DUMP_XZR_ZERO_EN to report index 31 as zero (XZR).
module regfile_dump_reader #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [IDX_W-1:0]  last_reg,
  output logic [IDX_W-1:0]  Rn,
  output logic [IDX_W-1:0]  Rm,
  input  logic [DATA_W-1:0] out1,
  input  logic [DATA_W-1:0] out2,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

`ifdef REGFILE_DUMP_XZR_ZERO_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] XZR_IDX = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND0,
    S_SEND1,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_last;
  logic [DATA_W-1:0]   r_buf0;
  logic [DATA_W-1:0]   r_buf1;
  logic [IDX_W-1:0]    r_rn;
  logic [IDX_W-1:0]    r_rm;
  logic                r_valid;
  logic [IDX_W-1:0]    r_didx;
  logic [DATA_W-1:0]   r_ddata;
  logic                r_busy;
  logic                r_done;

  logic [IDX_W-1:0]    w_idx_p1;
  logic [IDX_W-1:0]    w_idx_p2;
  logic [IDX_W-1:0]    w_idx_p3;
  logic [IDX_W-1:0]    w_first_p1;

  assign w_idx_p1   = r_idx + IDX_W'(1);
  assign w_idx_p2   = r_idx + IDX_W'(2);
  assign w_idx_p3   = r_idx + IDX_W'(3);
  assign w_first_p1 = first_reg + IDX_W'(1);

  // The zero register reads as zero only when XZR semantics are compiled in.
  function automatic logic [DATA_W-1:0] xzr_mask(input logic [IDX_W-1:0] idx,
                                                 input logic [DATA_W-1:0] data);
    return (XZR_EN && (idx == XZR_IDX)) ? '0 : data;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_valid <= 1'b0;
      r_didx  <= '0;
      r_ddata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            r_last <= last_reg;
            if (first_reg <= last_reg) begin
              r_state <= S_FETCH;
              r_idx   <= first_reg;
              r_rn    <= first_reg;
              r_rm    <= w_first_p1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          r_buf0  <= out1;
          r_buf1  <= out2;
          r_rn    <= '0;
          r_rm    <= '0;
          r_valid <= 1'b1;
          r_didx  <= r_idx;
          r_ddata <= xzr_mask(r_idx, out1);
          r_state <= S_SEND0;
        end

        S_SEND0: begin
          if (dump_ready) begin
            if (r_idx == r_last) begin
              r_valid <= 1'b0;
              r_didx  <= '0;
              r_ddata <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_didx  <= w_idx_p1;
              r_ddata <= xzr_mask(w_idx_p1, r_buf1);
              r_state <= S_SEND1;
            end
          end
        end

        S_SEND1: begin
          if (dump_ready) begin
            r_valid <= 1'b0;
            r_didx  <= '0;
            r_ddata <= '0;
            if (w_idx_p1 == r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // idx+1 < last here, so idx+2 <= last and never wraps.
              r_idx   <= w_idx_p2;
              r_rn    <= w_idx_p2;
              r_rm    <= w_idx_p3;
              r_state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Rn         = r_rn;
  assign Rm         = r_rm;
  assign dump_valid = r_valid;
  assign dump_idx   = r_didx;
  assign dump_data  = r_ddata;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
